// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access unit with store formatting and load extension
// Ports: i_clk/i_rst clock and async reset; i_memaccess/i_memwrite/i_ldop/i_sop/i_addr/i_wdata
// describe the memory-stage instruction; o_stall/o_done/o_rdata/o_misaligned report to the pipeline;
// o_mem_* and i_mem_* form the request/grant/rvalid data-memory interface.
package lsu_pkg;
    typedef enum logic [2:0] {LB, LH, LW, LBU, LHU} t_ldop;
    typedef enum logic [1:0] {SB, SH, SW} t_sop;
endpackage

module load_store_unit
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_memaccess,
    input  logic        i_memwrite,
    input  t_ldop       i_ldop,
    input  t_sop        i_sop,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} t_state;

    t_state      r_state;
    logic [31:0] r_addr;
    logic        r_we;
    t_ldop       r_ldop;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_offer;
    logic        w_misaligned;
    logic        w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;

    // Gated by reset so the combinational outputs also read 0 while i_rst is high.
    assign w_offer      = ~i_rst & (r_state == IDLE) & i_memaccess;
    assign w_misaligned = i_memwrite ? ((i_sop == SH) & i_addr[0]) | ((i_sop == SW) & (|i_addr[1:0]))
                                     : ((i_ldop == LH | i_ldop == LHU) & i_addr[0]) | ((i_ldop == LW) & (|i_addr[1:0]));
    assign w_accept     = w_offer & ~w_misaligned;

    assign w_be    = ~i_memwrite    ? 4'b1111 :
                     (i_sop == SB)  ? 4'b0001 << i_addr[1:0] :
                     (i_sop == SH)  ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
    assign w_wdata = (i_sop == SB)  ? {4{i_wdata[7:0]}} :
                     (i_sop == SH)  ? {2{i_wdata[15:0]}} : i_wdata;

    assign w_byte  = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half  = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    assign w_ldata = (r_ldop == LB)  ? {{24{w_byte[7]}}, w_byte} :
                     (r_ldop == LBU) ? {24'b0, w_byte} :
                     (r_ldop == LH)  ? {{16{w_half[15]}}, w_half} :
                     (r_ldop == LHU) ? {16'b0, w_half} : i_mem_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_ldop  <= LB;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_addr  <= i_addr;
                    r_we    <= i_memwrite;
                    r_ldop  <= i_ldop;
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_state <= REQ;
                end
                REQ: if (i_mem_gnt) r_state <= r_we ? DONE : WAIT;
                WAIT: if (i_mem_rvalid) begin
                    r_rdata <= w_ldata;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_stall      = w_accept | (r_state == REQ) | (r_state == WAIT);
    assign o_done       = (r_state == DONE);
    assign o_rdata      = r_rdata;
    assign o_misaligned = w_offer & w_misaligned;
    assign o_mem_req    = (r_state == REQ);
    assign o_mem_we     = (r_state == REQ) & r_we;
    assign o_mem_addr   = {r_addr[31:2], 2'b00};
    assign o_mem_be     = r_be;
    assign o_mem_wdata  = r_wdata;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock, i_clk; reset i_rst SHALL be asynchronous and active-high.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_memaccess  in  1  memory-stage instruction is a load or store.
- i_memwrite  in  1  1 = store, 0 = load.
- i_ldop  in  t_ldop  LB/LH/LW/LBU/LHU.
- i_sop  in  t_sop  SB/SH/SW.
- i_addr  in  32  byte address from the ALU.
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  hold the pipeline.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load result.
- o_misaligned  out  1  misaligned access rejected.
- o_mem_req  out  1  data memory request.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  32  word address, bits [1:0] = 0.
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  32  lane-aligned store data.
- i_mem_gnt  in  1  request accepted.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  32  read data word.

Function
REQ-003 The FSM SHALL have four states, IDLE, REQ, WAIT and DONE, with reset state IDLE.
REQ-004 In IDLE, when i_memaccess=1 and the access is aligned, the block SHALL register addr, op, we and formatted wdata/be, then go to REQ.
REQ-005 Misalignment SHALL be defined as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- A misaligned access in IDLE SHALL assert o_misaligned combinationally.
- It SHALL issue no request, leave the state in IDLE, and keep o_stall=0.
REQ-006 o_stall SHALL equal (IDLE & i_memaccess & aligned) | REQ | WAIT; it SHALL be 0 in DONE.
REQ-007 In REQ, o_mem_req SHALL be 1, and addr/we/be/wdata SHALL hold stable until the cycle in which i_mem_gnt=1.
REQ-008 On grant in REQ: a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-009 i_mem_rvalid SHALL be honoured only in WAIT, and SHALL be ignored in IDLE, REQ and DONE.
REQ-010 In WAIT, on i_mem_rvalid the block SHALL register the extended o_rdata and go to DONE; there SHALL be no timeout.
REQ-011 In DONE, o_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
- i_memaccess SHALL be ignored in DONE (the same instruction is still presented).
REQ-012 Store formatting SHALL be:
- SB: be = 4'b0001 << addr[1:0], wdata = byte replicated ×4.
- SH: be = 4'b0011 << {addr[1],1'b0}, wdata = halfword replicated ×2.
- SW: be = 4'b1111, wdata unchanged.
REQ-013 Loads SHALL drive be = 4'b1111 and we = 0.
REQ-014 Load extraction SHALL select the byte lane by addr[1:0] and the halfword by addr[1].
- LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word through.
REQ-015 o_rdata SHALL hold its value until the next load completes; stores SHALL NOT modify o_rdata.
REQ-016 Latency SHALL be:
- store: grant + 1 cycle to o_done.
- load: rvalid + 1 cycle to o_done.
- minimum: 3 cycles from acceptance to o_done for a store, 4 for a load.
REQ-017 o_mem_addr SHALL equal {addr[31:2], 2'b00}.

Reset
REQ-018 While i_rst=1, every output SHALL be 0 and the state SHALL be IDLE; this SHALL take effect immediately (asynchronous), including mid-transaction.
REQ-019 After reset, a late i_mem_rvalid from an aborted load SHALL be ignored and SHALL NOT produce o_done.

Verification
REQ-020 LB: addr=0x1003, mem word 0x80FF_1234, gnt in REQ cycle 1, rvalid one cycle later -> o_rdata=0xFFFF_FF80, o_done pulse once, o_stall low in the DONE cycle.
REQ-021 SH: addr=0x2002, wdata=0x0000_BEEF, gnt held low for 3 cycles -> req/addr=0x2000/be=4'b1100/wdata=0xBEEF_BEEF stable for all 4 cycles, o_done one cycle after gnt, o_rdata unchanged.
REQ-022 LW with addr=0x0001 -> o_misaligned=1 the same cycle, o_mem_req=0, o_stall=0, state stays IDLE.
REQ-023 LHU: addr=0x0002, mem word 0x8001_0000 -> o_rdata=0x0000_8001; an LH with the same data -> 0xFFFF_8001.
REQ-024 i_rst pulsed while in WAIT, then rvalid arrives -> outputs 0 immediately, no o_done; a following load completes normally.
REQ-025 Back-to-back loads (i_memaccess high continuously) -> exactly one request per instruction, no re-issue during DONE.
